// File: rtl/aes_round_key_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_key_gen_if
// Description : Key-load, round-key request and response bundle for
//               aes_round_key_gen.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_round_key_gen_if;
    logic         key_load;
    logic [127:0] key_in;
    logic         req_valid;
    logic [3:0]   req_round;
    logic         req_ready;
    logic         rk_valid;
    logic [127:0] rk_o;
    logic         err;
    logic         busy;

    modport master (
        output key_load, key_in, req_valid, req_round,
        input  req_ready, rk_valid, rk_o, err, busy
    );

    modport slave (
        input  key_load, key_in, req_valid, req_round,
        output req_ready, rk_valid, rk_o, err, busy
    );
endinterface
`default_nettype wire

// File: rtl/aes_round_key_gen.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_key_gen
// Description : On-demand AES-128 round-key generator, one expanded word per
//               cycle. Optional round-key cache enabled by AES_RKEY_CACHE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_key_gen (
    input  wire logic          clk,
    input  wire logic          rst_n,
    aes_round_key_gen_if.slave bus
);
    typedef enum logic [1:0] {
        NOKEY = 2'd0,
        READY = 2'd1,
        GEN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bits [8*(255-b)+7 -: 8]; 255-b is simply ~b.
    function automatic logic [7:0] f_sbox(input logic [7:0] b);
        return c_sbox[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] f_rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t       r_state;
    logic [127:0] r_win;
    logic [3:0]   r_cur_round;
    logic [3:0]   r_target;
    logic [1:0]   r_word_cnt;
    logic [127:0] r_rk;
    logic         r_rk_valid;
    logic         r_err;
    logic         r_busy;

    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_new;
    logic [127:0] w_win_next;
    logic [3:0]   w_next_round;
    logic         w_round_done;

    assign w_next_round = r_cur_round + 4'd1;
    assign w_rot        = {r_win[23:0], r_win[31:24]};

    generate
        for (genvar g = 0; g < 4; g++) begin : g_sbox
            assign w_sub[8*g +: 8] = f_sbox(w_rot[8*g +: 8]);
        end
    endgenerate

    // Window is w0..w3 MSB-first; w3 (LSBs) is w[i-1], w0 (MSBs) is w[i-4].
    assign w_t          = (r_word_cnt == 2'd0) ? (w_sub ^ {f_rcon(w_next_round), 24'h0})
                                               : r_win[31:0];
    assign w_new        = r_win[127:96] ^ w_t;
    assign w_win_next   = {r_win[95:0], w_new};
    assign w_round_done = (r_state == GEN) && (r_word_cnt == 2'd3);

`ifdef AES_RKEY_CACHE_EN
    logic [127:0] r_cache [0:10];
    logic [10:0]  r_cache_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cache_vld <= '0;
        end else if (bus.key_load) begin
            r_cache_vld <= 11'd1;
        end else if (w_round_done) begin
            r_cache_vld[w_next_round] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.key_load) begin
            r_cache[0] <= bus.key_in;
        end else if (w_round_done) begin
            r_cache[w_next_round] <= w_win_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= NOKEY;
            r_win       <= '0;
            r_cur_round <= '0;
            r_target    <= '0;
            r_word_cnt  <= '0;
            r_rk        <= '0;
            r_rk_valid  <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rk_valid <= 1'b0;
            r_err      <= 1'b0;
            if (bus.key_load) begin
                r_state     <= READY;
                r_win       <= bus.key_in;
                r_cur_round <= '0;
                r_word_cnt  <= '0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    NOKEY: begin
                        if (bus.req_valid) r_err <= 1'b1;
                    end
                    READY: begin
                        if (bus.req_valid) begin
                            if (bus.req_round > 4'd10) begin
                                r_err <= 1'b1;
                            end else if (bus.req_round == r_cur_round) begin
                                r_rk       <= r_win;
                                r_rk_valid <= 1'b1;
                                r_busy     <= 1'b1;
                                r_state    <= RESP;
                            end else if (bus.req_round > r_cur_round) begin
                                r_target   <= bus.req_round;
                                r_word_cnt <= '0;
                                r_busy     <= 1'b1;
                                r_state    <= GEN;
                            end else begin
`ifdef AES_RKEY_CACHE_EN
                                if (r_cache_vld[bus.req_round]) begin
                                    r_rk       <= r_cache[bus.req_round];
                                    r_rk_valid <= 1'b1;
                                    r_busy     <= 1'b1;
                                    r_state    <= RESP;
                                end else begin
                                    r_err <= 1'b1;
                                end
`else
                                r_err <= 1'b1;
`endif
                            end
                        end
                    end
                    GEN: begin
                        r_win      <= w_win_next;
                        r_word_cnt <= r_word_cnt + 2'd1;
                        if (r_word_cnt == 2'd3) begin
                            r_cur_round <= w_next_round;
                            if (w_next_round == r_target) begin
                                r_rk       <= w_win_next;
                                r_rk_valid <= 1'b1;
                                r_state    <= RESP;
                            end
                        end
                    end
                    RESP: begin
                        r_busy  <= 1'b0;
                        r_state <= READY;
                    end
                    default: r_state <= NOKEY;
                endcase
            end
        end
    end

    // Ready drops combinationally so key_load always wins over a same-cycle request.
    assign bus.req_ready = ((r_state == NOKEY) || (r_state == READY)) && !bus.key_load;
    assign bus.rk_valid  = r_rk_valid;
    assign bus.rk_o      = r_rk;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_aes_round_key_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_key_gen
// Description : Directed vector bench for aes_round_key_gen (FIPS-197 keys).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_key_gen;
    localparam logic [127:0] c_k1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_k1_r1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_k1_r3 = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] c_k1_r7 = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    localparam logic [127:0] c_k1_r10= 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_k2    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_k2_r1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

    typedef struct {
        logic [3:0]   round;
        logic         exp_err;
        int           exp_lat;
        logic [127:0] exp_rk;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    aes_round_key_gen_if bus();

    aes_round_key_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        @(negedge clk);
        bus.key_load = 1'b1;
        bus.key_in   = k;
        @(negedge clk);
        bus.key_load = 1'b0;
    endtask

    // Latency counts negedge samples after the accepting posedge (1 = next cycle).
    task automatic do_req(input logic [3:0] rnd, output logic got_v, output logic got_e,
                          output logic [127:0] got_rk, output int lat, output logic busy_ok);
        got_v = 1'b0; got_e = 1'b0; got_rk = '0; lat = 0; busy_ok = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_round = rnd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (i > 1) @(negedge clk);
            if (bus.rk_valid && bus.err) check("err_and_valid", 128'd1, 128'd0);
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.rk_valid || bus.err) begin
                got_v  = bus.rk_valid;
                got_e  = bus.err;
                got_rk = bus.rk_o;
                lat    = i;
                break;
            end
        end
    endtask

    vec_t         vecs [12];
    logic         v, e, bok;
    logic [127:0] rk;
    int           lat, n_v, n_e;

    initial begin
        bus.key_load = 1'b0; bus.key_in = '0; bus.req_valid = 1'b0; bus.req_round = '0;

        vecs[0]  = '{4'd0,  1'b0, 1,  c_k1};
        vecs[1]  = '{4'd1,  1'b0, 5,  c_k1_r1};
        vecs[2]  = '{4'd11, 1'b1, 1,  '0};
        vecs[3]  = '{4'd3,  1'b0, 9,  c_k1_r3};
        vecs[4]  = '{4'd3,  1'b0, 1,  c_k1_r3};
        vecs[5]  = '{4'd10, 1'b0, 29, c_k1_r10};
        vecs[6]  = '{4'd12, 1'b1, 1,  '0};
        vecs[7]  = '{4'd15, 1'b1, 1,  '0};
`ifdef AES_RKEY_CACHE_EN
        vecs[8]  = '{4'd1,  1'b0, 1,  c_k1_r1};
        vecs[9]  = '{4'd7,  1'b0, 1,  c_k1_r7};
        vecs[11] = '{4'd0,  1'b0, 1,  c_k1};
`else
        vecs[8]  = '{4'd1,  1'b1, 1,  '0};
        vecs[9]  = '{4'd7,  1'b1, 1,  '0};
        vecs[11] = '{4'd0,  1'b1, 1,  '0};
`endif
        vecs[10] = '{4'd10, 1'b0, 1,  c_k1_r10};

        repeat (3) @(negedge clk);
        check("rst_rk_o",     bus.rk_o, '0);
        check("rst_outputs",  {125'd0, bus.rk_valid, bus.err, bus.busy}, '0);
        check("rst_req_ready", {127'd0, bus.req_ready}, 128'd1);
        rst_n = 1'b1;

        do_req(4'd0, v, e, rk, lat, bok);
        check("nokey_err",   {127'd0, e}, 128'd1);
        check("nokey_noval", {127'd0, v}, 128'd0);

        load_key(c_k1);
        foreach (vecs[i]) begin
            do_req(vecs[i].round, v, e, rk, lat, bok);
            check($sformatf("vec%0d_err", i),   {127'd0, e}, {127'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_valid", i), {127'd0, v}, {127'd0, ~vecs[i].exp_err});
            check($sformatf("vec%0d_lat", i),   128'(lat), 128'(vecs[i].exp_lat));
            if (!vecs[i].exp_err) check($sformatf("vec%0d_rk", i), rk, vecs[i].exp_rk);
        end

        // Full expansion from round 0, busy held throughout.
        load_key(c_k1);
        do_req(4'd10, v, e, rk, lat, bok);
        check("r10_lat",  128'(lat), 128'd41);
        check("r10_rk",   rk, c_k1_r10);
        check("r10_busy", {127'd0, bok}, 128'd1);

        // key_load mid-GEN, then key_load racing a request while READY.
        load_key(c_k1);
        @(negedge clk); bus.req_valid = 1'b1; bus.req_round = 4'd10;
        @(negedge clk); bus.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        bus.key_load = 1'b1; bus.key_in = c_k2;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_round = 4'd0;
        #1 check("kl_prio_ready", {127'd0, bus.req_ready}, 128'd0);
        @(negedge clk);
        bus.key_load = 1'b0; bus.req_valid = 1'b0;
        n_v = 0; n_e = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.rk_valid) n_v++;
            if (bus.err) n_e++;
        end
        check("kl_abort_noval", 128'(n_v), 128'd0);
        check("kl_abort_noerr", 128'(n_e), 128'd0);
        do_req(4'd0, v, e, rk, lat, bok);
        check("k2_r0_rk",  rk, c_k2);
        check("k2_r0_lat", 128'(lat), 128'd1);
        do_req(4'd1, v, e, rk, lat, bok);
        check("k2_r1_rk",  rk, c_k2_r1);
        check("k2_r1_lat", 128'(lat), 128'd5);

        // Reset dropped mid-GEN.
        @(negedge clk); bus.req_valid = 1'b1; bus.req_round = 4'd9;
        @(negedge clk); bus.req_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", {127'd0, bus.busy}, 128'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rk_o", bus.rk_o, '0);
        check("mid_rst_outs", {125'd0, bus.rk_valid, bus.err, bus.busy}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {127'd0, bus.req_ready}, 128'd1);
        n_v = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.rk_valid) n_v++;
        end
        check("post_rst_noval", 128'(n_v), 128'd0);
        do_req(4'd0, v, e, rk, lat, bok);
        check("post_rst_nokey_err", {127'd0, e}, 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/aes_round_key_gen.md
AES_ROUND_KEY_GEN -- requirements
Module: aes_round_key_gen

Interface
REQ-001 SHALL have no parameters; key width is fixed at 128 bits and round index at 4 bits.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 key_load  input  1  single-cycle pulse; capture key_in as the master key.
REQ-006 key_in  input  128  master key; key_in[127:120] = byte 0, w0 = key_in[127:96].
REQ-007 req_valid  input  1  round-key request valid.
REQ-008 req_round  input  4  requested round index, 0..10.
REQ-009 req_ready  output  1  request accepted when req_valid & req_ready.
REQ-010 rk_valid  output  1  single-cycle pulse; rk_o holds the requested round key.
REQ-011 rk_o  output  128  round key, same byte order as key_in; holds its value while rk_valid is low.
REQ-012 err  output  1  single-cycle pulse; request rejected.
REQ-013 busy  output  1  high in GEN and RESP.

Function
REQ-014 SHALL implement the FSM states NOKEY, READY, GEN and RESP.
REQ-015 NOKEY: req_ready=1; any accepted request -> err pulse next cycle; stay in NOKEY.
REQ-016 key_load in any state -> READY next cycle, with the working window loaded as w0..w3 = key_in and cur_round=0; any in-flight generation is discarded and no rk_valid is issued for it.
REQ-017 key_load has priority over a request in the same cycle; that request is not accepted (req_ready=0 in any cycle where key_load=1).
REQ-018 READY: req_ready=1; on an accepted request with round r, the next state depends on r:
  - r>10 -> err pulse next cycle, stay in READY;
  - r==cur_round -> RESP;
  - r>cur_round -> GEN with target r;
  - r<cur_round -> see Configuration.
REQ-019 GEN: generate one word per cycle; w[i] = w[i-4] ^ t, where t = SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0} if i%4==0, else t = w[i-1].
REQ-020 Rcon for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-021 GEN: the window shifts by one word per cycle; cur_round increments every 4th word; on reaching the target round -> RESP.
REQ-022 GEN SHALL use 4 parallel S-box byte substitutions (combinational lookups, FIPS-197 forward S-box).
REQ-023 RESP: rk_valid=1 and rk_o=window for one cycle, then -> READY.
REQ-024 Latency from request acceptance to rk_valid SHALL be 4*(r-cur_round)+1 cycles; r==cur_round gives 1 cycle.
REQ-025 req_ready SHALL be 0 in GEN and RESP; req_valid is ignored there.
REQ-026 err and rk_valid SHALL never be asserted in the same cycle.

Reset
REQ-027 rst_n low SHALL asynchronously force NOKEY and clear cur_round, the window, rk_o, rk_valid, err and busy to 0.
REQ-028 After reset, req_ready=1 (NOKEY).
REQ-029 Reset mid-GEN SHALL abandon generation with no rk_valid.

Configuration
REQ-030 Macro AES_RKEY_CACHE_EN.
REQ-031 With AES_RKEY_CACHE_EN defined:
  - each completed round key is stored in an 11x128 register array, valid bits cleared by reset and key_load;
  - a request for r<=cur_round is served from the array via RESP with 1-cycle latency.
REQ-032 Without AES_RKEY_CACHE_EN:
  - no array is built;
  - a request with r<cur_round -> err pulse next cycle, stay in READY, window unchanged.

Verification
REQ-033 key_load key_in=2b7e151628aed2a6abf7158809cf4f3c, request r=0 -> rk_valid 1 cycle later, rk_o=2b7e151628aed2a6abf7158809cf4f3c.
REQ-034 Same key, request r=1 from cur_round=0 -> rk_valid after 5 cycles, rk_o=a0fafe1788542cb123a339392a6c7605.
REQ-035 Same key, request r=10 from cur_round=0 -> rk_valid after 41 cycles, rk_o=d014f9a8c9ee2589e13f0cc8b6630ca6; busy high throughout.
REQ-036 Request r=11 -> err pulse, no rk_valid; request r=1 after reaching round 10:
  - with AES_RKEY_CACHE_EN, rk_valid after 1 cycle, rk_o=a0fafe17...7605;
  - without it, err pulse.
REQ-037 key_load asserted mid-GEN with a new key -> no rk_valid for the old request; a subsequent r=0 request returns the new key.
REQ-038 Request before any key_load -> err; rst_n dropped mid-GEN -> all outputs 0 immediately and req_ready=1 after release.
